// File: rtl/serial_xor_controller_pkg.sv
// Shared constants and types for the bit-serial XOR/parity sequencer.
package serial_xor_controller_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam logic MODE_XOR = 1'b0;
  localparam logic MODE_PAR = 1'b1;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StRun  = RUN,
    StDone = DONE
  } state_e;

endpackage

// File: rtl/C_XOR.sv
// Mux-based two-input XOR cell: b selects between a and its complement.
module C_XOR (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);

  assign y_o = b_i ? ~a_i : a_i;

endmodule

// File: rtl/serial_xor_counter.sv
// Bit counter for the serial sequencer, with clear, enable and last-bit flag.
module serial_xor_counter #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = $clog2(W)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CW'(W - 1));

endmodule

// File: rtl/serial_xor_controller.sv
// Bit-serial XOR / parity sequencer time-sharing one C_XOR cell, LSB first.
module serial_xor_controller
  import serial_xor_controller_pkg::*;
#(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         parity
);

  state_e         state_q, state_d;
  logic [W-1:0]   a_sh_q, a_sh_d;
  logic [W-1:0]   b_sh_q, b_sh_d;
  logic           mode_q, mode_d;
  logic [W-1:0]   result_q, result_d;
  logic           parity_q, parity_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           cnt_clr, cnt_en, cnt_last;
  logic           cell_a, cell_b, cell_y;

  // Parity mode feeds the running parity back into the cell.
  assign cell_a = (mode_q == MODE_PAR) ? parity_q  : a_sh_q[0];
  assign cell_b = (mode_q == MODE_PAR) ? a_sh_q[0] : b_sh_q[0];

  C_XOR u_cell (
    .a_i (cell_a),
    .b_i (cell_b),
    .y_o (cell_y)
  );

  serial_xor_counter #(
    .W  (W),
    .CW (CW)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .last_o (cnt_last)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    mode_d   = mode_q;
    result_d = result_q;
    parity_d = parity_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d   = a_in;
          b_sh_d   = b_in;
          mode_d   = mode;
          result_d = '0;
          parity_d = 1'b0;
          cnt_clr  = 1'b1;
          state_d  = StRun;
        end
      end
      StRun: begin
        a_sh_d = {1'b0, a_sh_q[W-1:1]};
        b_sh_d = {1'b0, b_sh_q[W-1:1]};
        cnt_en = 1'b1;
        if (mode_q == MODE_XOR) begin
          result_d = {cell_y, result_q[W-1:1]};
        end else begin
          parity_d = cell_y;
        end
        if (cnt_last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Status outputs are registered from the next state so they stay glitch-free.
    busy_d = (state_d == StRun);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      mode_q   <= MODE_XOR;
      result_q <= '0;
      parity_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      parity_q <= parity_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign parity = parity_q;

endmodule
